// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction memory loader.
// Holds the loader FSM encoding, the NOP word and the default geometry.
package instr_mem_pkg;

    localparam int DEF_NBITS  = 32;
    localparam int DEF_DEPTH  = 256;
    localparam int DEF_BYTE_W = 8;

    localparam logic [DEF_NBITS-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs a most-significant-byte-first byte stream into NBITS-wide words.
// o_word/o_word_done are combinational so the word can be written on the same edge as its last byte.
module word_assembler #(
    parameter int NBITS  = 32,
    parameter int BYTE_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_byte_valid,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [NBITS-1:0]  o_word,
    output logic              o_word_done
);

    localparam int BPW   = NBITS / BYTE_W;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [NBITS-1:0] asm_reg;
    logic [CNT_W-1:0] byte_cnt_reg;

    assign o_word      = {asm_reg[NBITS-BYTE_W-1:0], i_byte};
    assign o_word_done = i_byte_valid && (byte_cnt_reg == CNT_W'(BPW - 1));

    // Clear wins over a byte so a terminated load drops any partial word.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            asm_reg      <= '0;
            byte_cnt_reg <= '0;
        end else if (i_clear) begin
            asm_reg      <= '0;
            byte_cnt_reg <= '0;
        end else if (i_byte_valid) begin
            asm_reg      <= o_word;
            byte_cnt_reg <= o_word_done ? '0 : byte_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/instr_memory_loader.sv
// Instruction memory with a byte-stream program loader and a 1-cycle fetch port.
// Fetches are ignored while a load is in progress; memory survives reset.
module instr_memory_loader
    import instr_mem_pkg::*;
#(
    parameter int NBITS  = DEF_NBITS,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int BYTE_W = DEF_BYTE_W,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_step,
    input  logic [NBITS-1:0]  i_pc,
    input  logic              i_load_start,
    input  logic              i_byte_valid,
    input  logic [BYTE_W-1:0] i_byte,
    input  logic              i_load_end,
    output logic [NBITS-1:0]  o_instruction,
    output logic              o_valid,
    output logic              o_pc_fault,
    output logic              o_busy,
    output logic [ADDR_W:0]   o_load_count,
    output logic              o_overflow
);

    load_state_t state_reg, state_next;

    logic [ADDR_W:0]  load_addr_reg;
    logic             overflow_reg;
    logic [NBITS-1:0] instr_reg;
    logic             valid_reg;
    logic             fault_reg;

    // Zero at power-up; deliberately untouched by reset.
    logic [NBITS-1:0] mem [DEPTH] = '{default: '0};

    logic             in_load;
    logic             asm_en;
    logic             asm_clear;
    logic [NBITS-1:0] asm_word;
    logic             word_done;
    logic             addr_full;
    logic             mem_we;
    logic             overflow_hit;
    logic             fetch_en;
    logic             pc_bad;

    assign in_load      = (state_reg == ST_LOAD);
    assign asm_en       = in_load && i_byte_valid && !i_load_start;
    assign asm_clear    = i_load_start || (in_load && i_load_end);
    assign addr_full    = (load_addr_reg == (ADDR_W+1)'(DEPTH));
    assign mem_we       = word_done && !addr_full;
    assign overflow_hit = word_done && addr_full;
    assign fetch_en     = i_step && !in_load;
    assign pc_bad       = (i_pc[1:0] != 2'b00) || (i_pc[NBITS-1:ADDR_W+2] != '0);

    word_assembler #(
        .NBITS  (NBITS),
        .BYTE_W (BYTE_W)
    ) u_word_assembler (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (asm_clear),
        .i_byte_valid (asm_en),
        .i_byte       (i_byte),
        .o_word       (asm_word),
        .o_word_done  (word_done)
    );

    always_comb begin
        state_next = state_reg;
        o_busy     = 1'b0;
        case (state_reg)
            ST_IDLE: if (i_load_start) state_next = ST_LOAD;
            ST_LOAD: begin
                o_busy = 1'b1;
                if (i_load_start)                    state_next = ST_LOAD;
                else if (i_load_end || overflow_hit) state_next = ST_DONE;
            end
            ST_DONE: if (i_load_start) state_next = ST_LOAD;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg     <= ST_IDLE;
            load_addr_reg <= '0;
            overflow_reg  <= 1'b0;
            instr_reg     <= '0;
            valid_reg     <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (i_load_start) begin
                load_addr_reg <= '0;
                overflow_reg  <= 1'b0;
            end else if (mem_we) begin
                load_addr_reg <= load_addr_reg + 1'b1;
            end else if (overflow_hit) begin
                overflow_reg <= 1'b1;
            end

            valid_reg <= fetch_en;
            if (fetch_en) begin
                if (pc_bad) begin
                    instr_reg <= NBITS'(NOP_INSTR);
                    fault_reg <= 1'b1;
                end else begin
                    instr_reg <= mem[i_pc[ADDR_W+1:2]];
                    fault_reg <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) mem[load_addr_reg[ADDR_W-1:0]] <= asm_word;
    end

    assign o_instruction = instr_reg;
    assign o_valid       = valid_reg;
    assign o_pc_fault    = fault_reg;
    assign o_load_count  = load_addr_reg;
    assign o_overflow    = overflow_reg;

endmodule

// File: tb/tb_instr_memory_loader.sv
// Directed bench for instr_memory_loader: load, fetch, faults, overflow, reset mid-load.
module tb_instr_memory_loader;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_step = 1'b0;
    logic [31:0] i_pc = '0;
    logic        i_load_start = 1'b0;
    logic        i_byte_valid = 1'b0;
    logic [7:0]  i_byte = '0;
    logic        i_load_end = 1'b0;
    logic [31:0] o_instruction;
    logic        o_valid;
    logic        o_pc_fault;
    logic        o_busy;
    logic [8:0]  o_load_count;
    logic        o_overflow;

    int          err_cnt = 0;
    int          chk_cnt = 0;
    logic        chk_hold = 1'b0;
    logic [31:0] hold_val = '0;

    instr_memory_loader dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_step        (i_step),
        .i_pc          (i_pc),
        .i_load_start  (i_load_start),
        .i_byte_valid  (i_byte_valid),
        .i_byte        (i_byte),
        .i_load_end    (i_load_end),
        .o_instruction (o_instruction),
        .o_valid       (o_valid),
        .o_pc_fault    (o_pc_fault),
        .o_busy        (o_busy),
        .o_load_count  (o_load_count),
        .o_overflow    (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_byte_valid = 1'b1;
        i_byte       = b;
        tick();
        i_byte_valid = 1'b0;
        if (chk_hold) begin
            check("step_in_load_valid", {31'd0, o_valid}, 32'd0);
            check("step_in_load_instr", o_instruction, hold_val);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic load_start();
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
    endtask

    task automatic load_end();
        i_load_end = 1'b1;
        tick();
        i_load_end = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] exp_instr, input logic exp_fault);
        i_step = 1'b1;
        i_pc   = pc;
        tick();
        i_step = 1'b0;
        check($sformatf("fetch_instr pc=%0d", pc), o_instruction, exp_instr);
        check($sformatf("fetch_valid pc=%0d", pc), {31'd0, o_valid}, 32'd1);
        check($sformatf("fetch_fault pc=%0d", pc), {31'd0, o_pc_fault}, {31'd0, exp_fault});
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rst_instr", o_instruction, 32'd0);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_fault", {31'd0, o_pc_fault}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_count", {23'd0, o_load_count}, 32'd0);
        check("rst_ovf", {31'd0, o_overflow}, 32'd0);
        i_reset = 1'b0;
        tick();
        fetch(32'd0, 32'd0, 1'b0);

        // Two-word program load
        load_start();
        check("load_busy", {31'd0, o_busy}, 32'd1);
        send_word(32'h2008_0005);
        check("load_count1", {23'd0, o_load_count}, 32'd1);
        send_word(32'h2009_0007);
        load_end();
        check("load_count2", {23'd0, o_load_count}, 32'd2);
        check("load_done_busy", {31'd0, o_busy}, 32'd0);
        check("load_ovf", {31'd0, o_overflow}, 32'd0);

        fetch(32'd0, 32'h2008_0005, 1'b0);
        fetch(32'd4, 32'h2009_0007, 1'b0);
        tick();
        check("hold_valid", {31'd0, o_valid}, 32'd0);
        check("hold_instr", o_instruction, 32'h2009_0007);
        fetch(32'd6, 32'd0, 1'b1);
        fetch(32'd1024, 32'd0, 1'b1);
        tick();
        check("hold_fault", {31'd0, o_pc_fault}, 32'd1);
        fetch(32'd0, 32'h2008_0005, 1'b0);

        // Steps during load are ignored; then reset after 2 bytes of word 3
        i_step   = 1'b1;
        i_pc     = 32'd4;
        load_start();
        hold_val = 32'h2009_0007;
        check("start_fetch_instr", o_instruction, hold_val);
        chk_hold = 1'b1;
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        send_word(32'h3333_3333);
        send_byte(8'h44);
        send_byte(8'h44);
        chk_hold = 1'b0;
        i_step   = 1'b0;
        check("pre_rst_count", {23'd0, o_load_count}, 32'd3);
        #2 i_reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        check("mid_rst_count", {23'd0, o_load_count}, 32'd0);
        check("mid_rst_instr", o_instruction, 32'd0);
        tick();
        i_reset = 1'b0;
        tick();
        fetch(32'd0, 32'h1111_1111, 1'b0);
        fetch(32'd8, 32'h3333_3333, 1'b0);
        fetch(32'd12, 32'd0, 1'b0);

        // Partial word discarded on load_end
        load_start();
        send_word(32'hAABB_CCDD);
        send_byte(8'h55);
        send_byte(8'h66);
        load_end();
        check("partial_count", {23'd0, o_load_count}, 32'd1);
        fetch(32'd4, 32'h2222_2222, 1'b0);

        // Completing byte together with load_end still writes
        load_start();
        send_byte(8'hCA);
        send_byte(8'hFE);
        send_byte(8'hBA);
        i_load_end = 1'b1;
        send_byte(8'hBE);
        i_load_end = 1'b0;
        check("end_same_count", {23'd0, o_load_count}, 32'd1);
        check("end_same_busy", {31'd0, o_busy}, 32'd0);
        fetch(32'd0, 32'hCAFE_BABE, 1'b0);

        // Overflow: 257 words into 256-deep memory
        load_start();
        for (int k = 0; k < 256; k++) send_word(32'h1000_0000 + k);
        check("ovf_count256", {23'd0, o_load_count}, 32'd256);
        check("ovf_busy256", {31'd0, o_busy}, 32'd1);
        check("ovf_flag256", {31'd0, o_overflow}, 32'd0);
        send_word(32'hDEAD_BEEF);
        check("ovf_flag", {31'd0, o_overflow}, 32'd1);
        check("ovf_busy", {31'd0, o_busy}, 32'd0);
        check("ovf_count", {23'd0, o_load_count}, 32'd256);
        fetch(32'd0, 32'h1000_0000, 1'b0);
        fetch(32'd1020, 32'h1000_00FF, 1'b0);
        load_start();
        check("restart_ovf", {31'd0, o_overflow}, 32'd0);
        check("restart_count", {23'd0, o_load_count}, 32'd0);
        load_end();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
